// File: rtl/umi_pkg.sv
// UMI command encoding shared by the traffic generator and its response checker.
package umi_pkg;

   localparam logic [4:0] UMI_REQ_READ   = 5'h01;
   localparam logic [4:0] UMI_RESP_READ  = 5'h02;
   localparam logic [4:0] UMI_REQ_WRITE  = 5'h03;
   localparam logic [4:0] UMI_RESP_WRITE = 5'h04;

   localparam int unsigned CMD_OPCODE_LSB = 0;
   localparam int unsigned CMD_OPCODE_W   = 5;

   typedef struct packed {
      logic [8:0] rsvd_hi;   // [31:23]
      logic       eom;       // [22]
      logic [5:0] rsvd_mid;  // [21:16]
      logic [7:0] len;       // [15:8]
      logic [2:0] size;      // [7:5]
      logic [4:0] opcode;    // [4:0]
   } umi_cmd_t;

   function automatic umi_cmd_t umi_build_cmd(input logic [4:0] opcode, input logic [2:0] size);
      umi_cmd_t c;
      c        = '0;
      c.opcode = opcode;
      c.size   = size;
      c.eom    = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/umi_traffic_gen_chk.sv
// Expected-response compare and saturating per-run error counter for umi_traffic_gen.
module umi_traffic_gen_chk
   import umi_pkg::*;
#(
   parameter int unsigned   DW      = 32,
   parameter int unsigned   AW      = 64,
   parameter int unsigned   CW      = 32,
   parameter logic [AW-1:0] SRCADDR = AW'(64'h0000_0001_0000_0000)
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          clear,
   input  logic          check,
   input  logic          is_read,
   input  logic          stray,
   input  logic          timeout_hit,
   input  logic [DW-1:0] exp_data,
   input  logic [CW-1:0] resp_cmd,
   input  logic [AW-1:0] resp_dstaddr,
   input  logic [DW-1:0] resp_data,
   output logic [15:0]   err_count
);

   logic [4:0]  exp_opcode;
   logic        mismatch;
   logic        bump;
   logic [15:0] err_d;
   logic        unused_cmd;

   assign unused_cmd = ^resp_cmd;
   assign exp_opcode = is_read ? UMI_RESP_READ : UMI_RESP_WRITE;

   assign mismatch = (resp_cmd[CMD_OPCODE_LSB +: CMD_OPCODE_W] != exp_opcode) ||
                     (resp_dstaddr != SRCADDR) ||
                     (is_read && (resp_data != exp_data));

   // The three sources are mutually exclusive, so a response never costs more than one.
   assign bump = (check && mismatch) || stray || timeout_hit;

   always_comb begin
      err_d = err_count;
      if (clear) begin
         err_d = {15'h0, bump};
      end else if (bump && (err_count != 16'hFFFF)) begin
         err_d = err_count + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         err_count <= '0;
      end else begin
         err_count <= err_d;
      end
   end

endmodule

// File: rtl/umi_traffic_gen.sv
// UMI write-then-readback initiator with one outstanding transaction and response checking.
// Optional macro UMI_TRAFFIC_GEN_TIMEOUT_EN adds a response-wait timeout and a timeout output.
module umi_traffic_gen
   import umi_pkg::*;
#(
   parameter int unsigned   DW      = 32,
   parameter int unsigned   AW      = 64,
   parameter int unsigned   CW      = 32,
   parameter int unsigned   NWORDS  = 16,
   parameter logic [AW-1:0] BASE    = '0,
   parameter logic [AW-1:0] SRCADDR = AW'(64'h0000_0001_0000_0000),
   parameter logic [31:0]   SEED    = 32'hA5A5_0000
) (
   input  logic          clk,
   input  logic          nreset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [15:0]   err_count,
`ifdef UMI_TRAFFIC_GEN_TIMEOUT_EN
   output logic          timeout,
`endif
   output logic          umi_req_out_valid,
   input  logic          umi_req_out_ready,
   output logic [CW-1:0] umi_req_out_cmd,
   output logic [AW-1:0] umi_req_out_dstaddr,
   output logic [AW-1:0] umi_req_out_srcaddr,
   output logic [DW-1:0] umi_req_out_data,
   input  logic          umi_resp_in_valid,
   output logic          umi_resp_in_ready,
   input  logic [CW-1:0] umi_resp_in_cmd,
   input  logic [AW-1:0] umi_resp_in_dstaddr,
   input  logic [AW-1:0] umi_resp_in_srcaddr,
   input  logic [DW-1:0] umi_resp_in_data
);

   localparam logic [2:0]    SIZE   = 3'($clog2(DW / 8));
   localparam logic [CW-1:0] WR_CMD = CW'(umi_build_cmd(UMI_REQ_WRITE, SIZE));
   localparam logic [CW-1:0] RD_CMD = CW'(umi_build_cmd(UMI_REQ_READ, SIZE));
   localparam logic [15:0]   LAST   = 16'(NWORDS - 1);

   typedef enum logic [2:0] {StIdle, StWrReq, StWrWait, StRdReq, StRdWait, StDone} state_t;

   state_t      state_q;
   logic [15:0] index_q;
   logic [15:0] nxt_idx;
   logic        resp_hs;
   logic        in_wait;
   logic        check;
   logic        stray;
   logic        tmo_hit;
   logic        advance;
   logic        last;
   logic        start_ok;
   logic        unused_srcaddr;

   function automatic logic [AW-1:0] word_addr(input logic [15:0] idx);
      return BASE + AW'(idx) * AW'(DW / 8);
   endfunction

   function automatic logic [DW-1:0] word_data(input logic [15:0] idx);
      return {(DW / 32){SEED ^ {16'h0, idx}}};
   endfunction

   assign unused_srcaddr = ^umi_resp_in_srcaddr;

   assign resp_hs  = umi_resp_in_valid && umi_resp_in_ready;
   assign in_wait  = (state_q == StWrWait) || (state_q == StRdWait);
   assign check    = resp_hs && in_wait;
   // Beats outside a wait state are drained and charged as errors.
   assign stray    = resp_hs && !in_wait;
   assign advance  = check || tmo_hit;
   assign last     = (index_q == LAST);
   assign start_ok = start && (state_q == StIdle);
   assign nxt_idx  = ((state_q == StIdle) || last) ? 16'd0 : index_q + 16'd1;

`ifdef UMI_TRAFFIC_GEN_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'd4094;

   logic [15:0] wait_cnt_q;

   assign tmo_hit = in_wait && !resp_hs && (wait_cnt_q == TMO_LAST);

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wait_cnt_q <= '0;
         timeout    <= 1'b0;
      end else begin
         if (!in_wait || advance) begin
            wait_cnt_q <= '0;
         end else begin
            wait_cnt_q <= wait_cnt_q + 16'd1;
         end
         if (start_ok) begin
            timeout <= 1'b0;
         end else if (tmo_hit) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q             <= StIdle;
         index_q             <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
         umi_req_out_valid   <= 1'b0;
         umi_req_out_cmd     <= '0;
         umi_req_out_dstaddr <= '0;
         umi_req_out_srcaddr <= '0;
         umi_req_out_data    <= '0;
         umi_resp_in_ready   <= 1'b0;
      end else begin
         umi_resp_in_ready <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_q             <= StWrReq;
                  index_q             <= '0;
                  busy                <= 1'b1;
                  done                <= 1'b0;
                  umi_req_out_valid   <= 1'b1;
                  umi_req_out_cmd     <= WR_CMD;
                  umi_req_out_dstaddr <= word_addr(nxt_idx);
                  umi_req_out_srcaddr <= SRCADDR;
                  umi_req_out_data    <= word_data(nxt_idx);
               end
            end
            StWrReq: begin
               if (umi_req_out_ready) begin
                  umi_req_out_valid <= 1'b0;
                  state_q           <= StWrWait;
               end
            end
            StWrWait: begin
               if (advance) begin
                  index_q             <= nxt_idx;
                  umi_req_out_valid   <= 1'b1;
                  umi_req_out_dstaddr <= word_addr(nxt_idx);
                  umi_req_out_srcaddr <= SRCADDR;
                  if (last) begin
                     state_q          <= StRdReq;
                     umi_req_out_cmd  <= RD_CMD;
                     umi_req_out_data <= '0;
                  end else begin
                     state_q          <= StWrReq;
                     umi_req_out_cmd  <= WR_CMD;
                     umi_req_out_data <= word_data(nxt_idx);
                  end
               end
            end
            StRdReq: begin
               if (umi_req_out_ready) begin
                  umi_req_out_valid <= 1'b0;
                  state_q           <= StRdWait;
               end
            end
            StRdWait: begin
               if (advance) begin
                  if (last) begin
                     state_q <= StDone;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                  end else begin
                     index_q             <= nxt_idx;
                     state_q             <= StRdReq;
                     umi_req_out_valid   <= 1'b1;
                     umi_req_out_cmd     <= RD_CMD;
                     umi_req_out_dstaddr <= word_addr(nxt_idx);
                     umi_req_out_srcaddr <= SRCADDR;
                     umi_req_out_data    <= '0;
                  end
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   umi_traffic_gen_chk #(
      .DW      (DW),
      .AW      (AW),
      .CW      (CW),
      .SRCADDR (SRCADDR)
   ) u_chk (
      .clk          (clk),
      .nreset       (nreset),
      .clear        (start_ok),
      .check        (check),
      .is_read      (state_q == StRdWait),
      .stray        (stray),
      .timeout_hit  (tmo_hit),
      .exp_data     (word_data(index_q)),
      .resp_cmd     (umi_resp_in_cmd),
      .resp_dstaddr (umi_resp_in_dstaddr),
      .resp_data    (umi_resp_in_data),
      .err_count    (err_count)
   );

endmodule

// File: tb/tb_umi_traffic_gen.sv
// Bench for umi_traffic_gen: memory-agent responder model with fault injection,
// random backpressure/latency, stray beats and mid-run reset.
module tb_umi_traffic_gen;

   localparam int          DW   = 32;
   localparam int          AW   = 64;
   localparam int          CW   = 32;
   localparam int          NW   = 4;
   localparam logic [63:0] SRC  = 64'h0000_0001_0000_0000;
   localparam logic [31:0] SEED = 32'hA5A5_0000;

   logic          clk = 1'b0;
   logic          nreset = 1'b0;
   logic          start = 1'b0;
   logic          busy, done;
   logic [15:0]   err_count;
`ifdef UMI_TRAFFIC_GEN_TIMEOUT_EN
   logic          timeout;
`endif
   logic          req_valid;
   logic          req_ready;
   logic [CW-1:0] req_cmd;
   logic [AW-1:0] req_dst, req_src;
   logic [DW-1:0] req_data;
   logic          resp_valid;
   logic          resp_ready;
   logic [CW-1:0] resp_cmd;
   logic [AW-1:0] resp_dst, resp_src;
   logic [DW-1:0] resp_data;

   int checks = 0;
   int errors = 0;

   // Responder controls (written only by the main sequence).
   bit bp_mode = 0, rand_lat = 0, corrupt2 = 0, bad_wr_op = 0, mute = 0;
   int stray_cnt = 0;

   // Log of accepted requests and the responder's memory (written only by the responder).
   logic [31:0] q_cmd[$];
   logic [63:0] q_dst[$];
   logic [63:0] q_src[$];
   logic [31:0] q_data[$];
   logic [31:0] mem[logic [63:0]];

   always #5 clk = ~clk;

   umi_traffic_gen #(
      .DW     (DW),
      .AW     (AW),
      .CW     (CW),
      .NWORDS (NW)
   ) dut (
      .clk                 (clk),
      .nreset              (nreset),
      .start               (start),
      .busy                (busy),
      .done                (done),
      .err_count           (err_count),
`ifdef UMI_TRAFFIC_GEN_TIMEOUT_EN
      .timeout             (timeout),
`endif
      .umi_req_out_valid   (req_valid),
      .umi_req_out_ready   (req_ready),
      .umi_req_out_cmd     (req_cmd),
      .umi_req_out_dstaddr (req_dst),
      .umi_req_out_srcaddr (req_src),
      .umi_req_out_data    (req_data),
      .umi_resp_in_valid   (resp_valid),
      .umi_resp_in_ready   (resp_ready),
      .umi_resp_in_cmd     (resp_cmd),
      .umi_resp_in_dstaddr (resp_dst),
      .umi_resp_in_srcaddr (resp_src),
      .umi_resp_in_data    (resp_data)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk_cmd(input logic [4:0] op);
      return 32'h0040_0000 | (32'd2 << 5) | {27'd0, op};
   endfunction

   // Memory-agent responder: stores writes, answers reads, one response per request.
   initial begin
      bit          pend, prev_stall;
      int          lat, stray_done;
      logic [31:0] rc, rdat, p_cmd, p_data;
      logic [63:0] rdst, rsrc, p_dst, p_src;
      pend = 0; prev_stall = 0; lat = 0; stray_done = 0;
      rc = '0; rdat = '0; rdst = '0; rsrc = '0;
      p_cmd = '0; p_data = '0; p_dst = '0; p_src = '0;
      resp_valid = 0; resp_cmd = '0; resp_dst = '0; resp_src = '0; resp_data = '0;
      req_ready = 1;
      forever begin
         @(posedge clk);
         if (prev_stall && req_valid)
            check("stall_stable", 64'({p_cmd, p_dst, p_src, p_data} ==
                                      {req_cmd, req_dst, req_src, req_data}), 64'd1);
         prev_stall = req_valid && !req_ready;
         p_cmd = req_cmd; p_dst = req_dst; p_src = req_src; p_data = req_data;
         if (req_valid && req_ready) begin
            q_cmd.push_back(req_cmd); q_dst.push_back(req_dst);
            q_src.push_back(req_src); q_data.push_back(req_data);
            if (req_cmd[4:0] == 5'h03) begin
               mem[req_dst] = req_data;
               rc   = mk_cmd((bad_wr_op && req_dst == 64'd0) ? 5'h02 : 5'h04);
               rdat = '0;
            end else begin
               rdat = mem.exists(req_dst) ? mem[req_dst] : 32'h0;
               if (corrupt2 && req_dst == 64'd8) rdat = rdat ^ 32'h1;
               rc = mk_cmd(5'h02);
            end
            rdst = req_src; rsrc = req_dst;
            pend = !mute;
            lat  = rand_lat ? int'($urandom_range(0, 3)) : 0;
         end
         #1;
         resp_valid = 0;
         if (stray_cnt != stray_done) begin
            stray_done++;
            resp_valid = 1; resp_cmd = mk_cmd(5'h04); resp_dst = SRC;
            resp_src = '0; resp_data = '0;
         end else if (pend) begin
            if (lat == 0) begin
               resp_valid = 1; resp_cmd = rc; resp_dst = rdst; resp_src = rsrc;
               resp_data = rdat; pend = 0;
            end else begin
               lat--;
            end
         end
         req_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic run(input int budget, input bit extra_start, output int busy_cyc);
      bit fin;
      fin = 0; busy_cyc = 0;
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < budget && !fin; i++) begin
         if (busy) busy_cyc++;
         if (done && !busy) fin = 1;
         else begin
            start = (extra_start && i == 5);
            @(negedge clk);
         end
      end
      start = 0;
      check("run_finished", 64'(fin), 64'd1);
   endtask

   task automatic check_reqs(input int base);
      check("req_count", 64'(q_cmd.size() - base), 64'(2 * NW));
      for (int k = 0; k < 2 * NW && base + k < q_cmd.size(); k++) begin
         int w;
         bit rd;
         w  = k % NW;
         rd = (k >= NW);
         check("req_cmd", 64'(q_cmd[base + k]), 64'(mk_cmd(rd ? 5'h01 : 5'h03)));
         check("req_dst", q_dst[base + k], 64'(w * 4));
         check("req_src", q_src[base + k], SRC);
         check("req_data", 64'(q_data[base + k]), rd ? 64'd0 : 64'(SEED ^ 32'(w)));
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"}, 64'(busy), 64'd0);
      check({tag, "_done"}, 64'(done), 64'd0);
      check({tag, "_err"}, 64'(err_count), 64'd0);
      check({tag, "_valid"}, 64'(req_valid), 64'd0);
      check({tag, "_cmd"}, 64'(req_cmd), 64'd0);
      check({tag, "_dst"}, req_dst, 64'd0);
      check({tag, "_src"}, req_src, 64'd0);
      check({tag, "_data"}, 64'(req_data), 64'd0);
      check({tag, "_rready"}, 64'(resp_ready), 64'd0);
   endtask

   initial begin
      int bc, base;
      repeat (3) @(negedge clk);
      check_reset_values("reset");
      nreset = 1;
      repeat (2) @(negedge clk);

      // Plain loopback run.
      base = q_cmd.size();
      run(200, 0, bc);
      check_reqs(base);
      check("loop_done", 64'(done), 64'd1);
      check("loop_err", 64'(err_count), 64'd0);
      check("loop_busy_cycles", 64'(bc), 64'(4 * NW));

      // Corrupted read data on word 2.
      corrupt2 = 1;
      run(200, 0, bc);
      corrupt2 = 0;
      check("corrupt_err", 64'(err_count), 64'd1);

      // Write response with read-response opcode.
      bad_wr_op = 1;
      run(200, 0, bc);
      bad_wr_op = 0;
      check("badop_err", 64'(err_count), 64'd1);
      check("badop_done", 64'(done), 64'd1);

      // Random backpressure and response latency, with a start pulse while busy.
      bp_mode = 1; rand_lat = 1;
      for (int r = 0; r < 4; r++) begin
         base = q_cmd.size();
         run(2000, 1, bc);
         check_reqs(base);
         check("bp_err", 64'(err_count), 64'd0);
      end
      bp_mode = 0; rand_lat = 0;
      repeat (3) @(negedge clk);

      // Stray beat while idle.
      stray_cnt++;
      repeat (4) @(negedge clk);
      check("stray_err", 64'(err_count), 64'd1);
      check("stray_busy", 64'(busy), 64'd0);
      check("stray_valid", 64'(req_valid), 64'd0);
      base = q_cmd.size();
      run(200, 0, bc);
      check_reqs(base);
      check("after_stray_err", 64'(err_count), 64'd0);

      // Reset in the read wait of word 1.
      base = q_cmd.size();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      for (int i = 0; i < 200 && q_cmd.size() < base + NW + 2; i++) @(negedge clk);
      check("pre_reset_reqs", 64'(q_cmd.size() - base), 64'(NW + 2));
      nreset = 0;
      #1;
      check_reset_values("midreset");
      repeat (3) @(negedge clk);
      nreset = 1;
      repeat (3) @(negedge clk);
      base = q_cmd.size();
      run(200, 0, bc);
      check_reqs(base);
      check("post_reset_err", 64'(err_count), 64'd0);
      check("post_reset_done", 64'(done), 64'd1);

`ifdef UMI_TRAFFIC_GEN_TIMEOUT_EN
      // Mute responder: every word times out.
      mute = 1;
      run(40000, 0, bc);
      mute = 0;
      check("tmo_err", 64'(err_count), 64'(2 * NW));
      check("tmo_flag", 64'(timeout), 64'd1);
      check("tmo_done", 64'(done), 64'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
